// File: rtl/mac_channel_sequencer_if.sv
// Bundles the window input stream, the weight write port and the result
// stream of the MAC channel sequencer. The sequencer connects as the slave;
// the window generator, weight loader and downstream stage together form the master.
interface mac_channel_sequencer_if #(
  parameter int KernelWidth = 3,
  parameter int WidthIn     = 2,
  parameter int WidthOut    = 32,
  parameter int WeightWidth = 2,
  parameter int OutChannels = 4
);
  localparam int KernelArea = KernelWidth * KernelWidth;
  localparam int ChanW      = (OutChannels > 1) ? $clog2(OutChannels) : 1;

  // Window input stream
  logic [KernelWidth-1:0][KernelWidth-1:0][WidthIn-1:0] window_i;
  logic                                                 valid_i;
  logic                                                 ready_o;

  // Weight bank write port
  logic                                wr_en_i;
  logic [ChanW-1:0]                    wr_addr_i;
  logic [KernelArea*WeightWidth-1:0]   wr_data_i;
  logic                                wr_ready_o;

  // Result stream
  logic signed [WidthOut-1:0] data_o;
  logic [ChanW-1:0]           channel_o;
  logic                       last_o;
  logic                       valid_o;
  logic                       ready_i;

  modport master (
    output window_i, valid_i, wr_en_i, wr_addr_i, wr_data_i, ready_i,
    input  ready_o, wr_ready_o, data_o, channel_o, last_o, valid_o
  );

  modport slave (
    input  window_i, valid_i, wr_en_i, wr_addr_i, wr_data_i, ready_i,
    output ready_o, wr_ready_o, data_o, channel_o, last_o, valid_o
  );
endinterface

// File: rtl/mac_channel_sequencer.sv
// Shares one MAC datapath across all output channels of a convolution layer.
// A KxK window is captured on the input handshake, then one signed result per
// channel is streamed out in channel order. Weights live in a per-channel bank
// that may only be rewritten while no window is being processed, so every
// channel of a window sees a consistent set of weights.
module mac_channel_sequencer #(
  parameter int KernelWidth = 3,
  parameter int WidthIn     = 2,
  parameter int WidthOut    = 32,
  parameter int WeightWidth = 2,
  parameter int OutChannels = 4
) (
  input logic                    clk_i,
  input logic                    rst_ni,
  mac_channel_sequencer_if.slave bus
);

  localparam int KernelArea = KernelWidth * KernelWidth;
  localparam int ChanW      = (OutChannels > 1) ? $clog2(OutChannels) : 1;
  localparam int WgtBits    = KernelArea * WeightWidth;

  typedef logic [KernelWidth-1:0][KernelWidth-1:0][WidthIn-1:0] window_t;

  typedef enum logic {
    IDLE,
    BUSY
  } state_e;

  state_e             state_q, state_d;
  logic [ChanW-1:0]   ch_q, ch_d;
  window_t            window_q, window_d;
  logic [WgtBits-1:0] bank_q [OutChannels];
  logic [WgtBits-1:0] bank_d [OutChannels];

  logic               is_last;
  logic               wr_fire;
  logic [WidthOut-1:0] mac_result;

  // Same arithmetic as the shared mac block: sign-extended weights, wrapping
  // accumulation; a 2-bit pixel is treated as a binary on/off gate.
  function automatic logic [WidthOut-1:0] mac_fn(input window_t win,
                                                 input logic [WgtBits-1:0] wts);
    logic [WidthOut-1:0] acc;
    logic [WidthOut-1:0] w_ext;
    logic [WidthOut-1:0] p_ext;
    acc = '0;
    for (int r = 0; r < KernelWidth; r++) begin
      for (int c = 0; c < KernelWidth; c++) begin
        w_ext = WidthOut'($signed(wts[(r*KernelWidth+c)*WeightWidth +: WeightWidth]));
        p_ext = WidthOut'(win[r][c]);
        if (WidthIn == 2) begin
          if (win[r][c] != '0) acc = acc + w_ext;
        end else begin
          acc = acc + w_ext * p_ext;
        end
      end
    end
    return acc;
  endfunction

  // Result datapath and stream flags, driven only from registered state so
  // the result never depends combinationally on the handshake inputs.
  always_comb begin
    is_last        = (state_q == BUSY) && (int'(ch_q) == OutChannels - 1);
    mac_result     = mac_fn(window_q, bank_q[ch_q]);
    bus.data_o     = $signed(mac_result);
    bus.channel_o  = ch_q;
    bus.last_o     = is_last;
    bus.valid_o    = (state_q == BUSY);
    bus.ready_o    = (state_q == IDLE);
    bus.wr_ready_o = (state_q == IDLE);
  end

  // Sequencer next state: capture a window when idle, walk the channels while
  // busy, advancing only on an accepted result.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    window_d = window_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          window_d = bus.window_i;
          ch_d     = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (bus.ready_i) begin
          if (is_last) begin
            state_d = IDLE;
            ch_d    = '0;
          end else begin
            ch_d = ch_q + ChanW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Weight bank update: writes only land while idle and for a real channel.
  always_comb begin
    bank_d  = bank_q;
    wr_fire = bus.wr_en_i && (state_q == IDLE) && (int'(bus.wr_addr_i) < OutChannels);
    if (wr_fire) bank_d[bus.wr_addr_i] = bus.wr_data_i;
  end

  // Sequencer state registers; reset drops any held window and pending results.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      ch_q     <= '0;
      window_q <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      window_q <= window_d;
    end
  end

  // Weight bank registers, cleared to all-zero weights on reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < OutChannels; i++) bank_q[i] <= '0;
    end else begin
      bank_q <= bank_d;
    end
  end

endmodule

// File: tb/tb_mac_channel_sequencer.sv
// Bench for the MAC channel sequencer. Two instances: a binary-image build
// with two channels and a 9-bit pixel build with four channels. Expected
// results are queued when a window is issued and popped by per-instance
// monitors on every accepted result.
module tb_mac_channel_sequencer;

  typedef logic [2:0][2:0][1:0] win_a_t;
  typedef logic [2:0][2:0][8:0] win_b_t;

  typedef struct {
    longint data;
    int     chan;
    bit     last;
  } exp_t;

  logic clk;
  logic rst_a_n;
  logic rst_b_n;

  int checks;
  int errors;

  exp_t q_a[$];
  exp_t q_b[$];

  mac_channel_sequencer_if #(.KernelWidth(3), .WidthIn(2), .WidthOut(32),
                             .WeightWidth(2), .OutChannels(2)) bus_a ();
  mac_channel_sequencer_if #(.KernelWidth(3), .WidthIn(9), .WidthOut(32),
                             .WeightWidth(2), .OutChannels(4)) bus_b ();

  mac_channel_sequencer #(.KernelWidth(3), .WidthIn(2), .WidthOut(32),
                          .WeightWidth(2), .OutChannels(2)) dut_a (
    .clk_i  (clk),
    .rst_ni (rst_a_n),
    .bus    (bus_a)
  );

  mac_channel_sequencer #(.KernelWidth(3), .WidthIn(9), .WidthOut(32),
                          .WeightWidth(2), .OutChannels(4)) dut_b (
    .clk_i  (clk),
    .rst_ni (rst_b_n),
    .bus    (bus_b)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case the sequence ever stalls.
  initial begin
    #50000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulusA(input win_a_t w, input logic v, input logic r);
    bus_a.window_i = w;
    bus_a.valid_i  = v;
    bus_a.ready_i  = r;
  endtask

  task automatic applyStimulusB(input win_b_t w, input logic v, input logic r);
    bus_b.window_i = w;
    bus_b.valid_i  = v;
    bus_b.ready_i  = r;
  endtask

  task automatic writeA(input logic en, input logic addr, input logic [17:0] data);
    bus_a.wr_en_i   = en;
    bus_a.wr_addr_i = addr;
    bus_a.wr_data_i = data;
  endtask

  task automatic writeB(input logic en, input logic [1:0] addr, input logic [17:0] data);
    bus_b.wr_en_i   = en;
    bus_b.wr_addr_i = addr;
    bus_b.wr_data_i = data;
  endtask

  task automatic pushA(input longint d, input int c, input bit l);
    q_a.push_back('{data: d, chan: c, last: l});
  endtask

  task automatic pushB(input longint d, input int c, input bit l);
    q_b.push_back('{data: d, chan: c, last: l});
  endtask

  // Binary window: bit r*3+c of ones sets pixel [r][c] to 1.
  function automatic win_a_t makeWinA(input logic [8:0] ones);
    win_a_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = ones[r*3+c] ? 2'd1 : 2'd0;
    return w;
  endfunction

  // Multi-bit window: every pixel is fill except the centre.
  function automatic win_b_t makeWinB(input logic [8:0] fill, input logic [8:0] centre);
    win_b_t w;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        w[r][c] = fill;
    w[1][1] = centre;
    return w;
  endfunction

  // Monitor for the binary instance: compare each accepted result in order.
  always @(negedge clk) begin
    if (rst_a_n && bus_a.valid_o && bus_a.ready_i) begin
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL a_unexpected_result actual=ch%0d expected=none", bus_a.channel_o);
      end else begin
        exp_t e;
        e = q_a.pop_front();
        checkOutput("a_data", bus_a.data_o, e.data);
        checkOutput("a_channel", bus_a.channel_o, e.chan);
        checkOutput("a_last", bus_a.last_o, e.last);
      end
    end
  end

  // Monitor for the multi-bit instance.
  always @(negedge clk) begin
    if (rst_b_n && bus_b.valid_o && bus_b.ready_i) begin
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL b_unexpected_result actual=ch%0d expected=none", bus_b.channel_o);
      end else begin
        exp_t e;
        e = q_b.pop_front();
        checkOutput("b_data", bus_b.data_o, e.data);
        checkOutput("b_channel", bus_b.channel_o, e.chan);
        checkOutput("b_last", bus_b.last_o, e.last);
      end
    end
  end

  // Directed stimulus for both instances.
  initial begin
    win_a_t five_ones;
    win_a_t corner;
    win_b_t w_full;
    win_b_t w_mixed;

    checks    = 0;
    errors    = 0;
    five_ones = makeWinA(9'b101010101);
    corner    = makeWinA(9'b000000001);
    w_full    = makeWinB(9'd255, 9'd255);
    w_mixed   = makeWinB(9'd1, 9'd100);

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    applyStimulusA('0, 1'b0, 1'b1);
    applyStimulusB('0, 1'b0, 1'b1);
    writeA(1'b0, 1'b0, '0);
    writeB(1'b0, 2'd0, '0);

    // ---------------- Binary instance ----------------
    tick();
    checkOutput("a_rst_valid_during", bus_a.valid_o, 0);
    tick();
    rst_a_n = 1'b1;
    #1;
    checkOutput("a_rst_valid", bus_a.valid_o, 0);
    checkOutput("a_rst_last", bus_a.last_o, 0);
    checkOutput("a_rst_channel", bus_a.channel_o, 0);
    checkOutput("a_rst_data", bus_a.data_o, 0);
    checkOutput("a_rst_ready", bus_a.ready_o, 1);
    checkOutput("a_rst_wr_ready", bus_a.wr_ready_o, 1);

    // ch0 all +1, ch1 all -1
    writeA(1'b1, 1'b0, {9{2'b01}});
    tick();
    writeA(1'b1, 1'b1, {9{2'b11}});
    tick();
    writeA(1'b0, 1'b0, '0);

    // Basic window: 5 then -5, idle again the cycle after the last handshake
    checkOutput("a_basic_ready_before", bus_a.ready_o, 1);
    applyStimulusA(five_ones, 1'b1, 1'b1);
    pushA(5, 0, 1'b0);
    pushA(-5, 1, 1'b1);
    tick();
    applyStimulusA('0, 1'b0, 1'b1);
    checkOutput("a_basic_t1_valid", bus_a.valid_o, 1);
    checkOutput("a_basic_t1_ready", bus_a.ready_o, 0);
    checkOutput("a_basic_t1_channel", bus_a.channel_o, 0);
    tick();
    checkOutput("a_basic_t2_channel", bus_a.channel_o, 1);
    checkOutput("a_basic_t2_last", bus_a.last_o, 1);
    tick();
    checkOutput("a_basic_t3_ready", bus_a.ready_o, 1);
    checkOutput("a_basic_t3_valid", bus_a.valid_o, 0);

    // Downstream stall on ch0 for three edges
    applyStimulusA(five_ones, 1'b1, 1'b0);
    pushA(5, 0, 1'b0);
    pushA(-5, 1, 1'b1);
    tick();
    applyStimulusA('0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("a_stall%0d_channel", i), bus_a.channel_o, 0);
      checkOutput($sformatf("a_stall%0d_data", i), bus_a.data_o, 5);
      checkOutput($sformatf("a_stall%0d_valid", i), bus_a.valid_o, 1);
      tick();
    end
    checkOutput("a_stall_end_channel", bus_a.channel_o, 0);
    bus_a.ready_i = 1'b1;
    tick();
    checkOutput("a_stall_next_channel", bus_a.channel_o, 1);
    tick();

    // Weight write attempted while busy must be ignored
    applyStimulusA(five_ones, 1'b1, 1'b1);
    pushA(5, 0, 1'b0);
    pushA(-5, 1, 1'b1);
    tick();
    applyStimulusA('0, 1'b0, 1'b1);
    writeA(1'b1, 1'b1, {9{2'b01}});
    checkOutput("a_busywr_wr_ready_t1", bus_a.wr_ready_o, 0);
    tick();
    checkOutput("a_busywr_wr_ready_t2", bus_a.wr_ready_o, 0);
    checkOutput("a_busywr_ch1_data", bus_a.data_o, -5);
    tick();
    writeA(1'b0, 1'b0, '0);

    // Clear ch0, then write ch0 entry0=+1 in the same cycle a window is accepted
    writeA(1'b1, 1'b0, '0);
    tick();
    writeA(1'b1, 1'b0, 18'h00001);
    applyStimulusA(corner, 1'b1, 1'b1);
    pushA(1, 0, 1'b0);
    pushA(-1, 1, 1'b1);
    tick();
    writeA(1'b0, 1'b0, '0);
    applyStimulusA('0, 1'b0, 1'b1);
    checkOutput("a_samecyc_t1_data", bus_a.data_o, 1);
    tick();
    tick();

    // ---------------- Multi-bit instance ----------------
    rst_b_n = 1'b1;
    #1;
    checkOutput("b_rst_valid", bus_b.valid_o, 0);
    checkOutput("b_rst_data", bus_b.data_o, 0);
    checkOutput("b_rst_ready", bus_b.ready_o, 1);

    // ch0 all -2, ch1 all +1, ch2 all -1, ch3 +1 at the centre only
    writeB(1'b1, 2'd0, {9{2'b10}});
    tick();
    writeB(1'b1, 2'd1, {9{2'b01}});
    tick();
    writeB(1'b1, 2'd2, {9{2'b11}});
    tick();
    writeB(1'b1, 2'd3, 18'h00100);
    tick();
    writeB(1'b0, 2'd0, '0);

    // Back-to-back windows with valid_i held high
    applyStimulusB(w_full, 1'b1, 1'b1);
    pushB(-4590, 0, 1'b0);
    pushB(2295, 1, 1'b0);
    pushB(-2295, 2, 1'b0);
    pushB(255, 3, 1'b1);
    tick();
    applyStimulusB(w_mixed, 1'b1, 1'b1);
    pushB(-216, 0, 1'b0);
    pushB(108, 1, 1'b0);
    pushB(-108, 2, 1'b0);
    pushB(100, 3, 1'b1);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("b_b2b_w1_channel%0d", c), bus_b.channel_o, c);
      checkOutput($sformatf("b_b2b_w1_valid%0d", c), bus_b.valid_o, 1);
      tick();
    end
    checkOutput("b_b2b_bubble_valid", bus_b.valid_o, 0);
    checkOutput("b_b2b_bubble_ready", bus_b.ready_o, 1);
    tick();
    applyStimulusB('0, 1'b0, 1'b1);
    checkOutput("b_b2b_w2_valid", bus_b.valid_o, 1);
    checkOutput("b_b2b_w2_channel", bus_b.channel_o, 0);
    checkOutput("b_b2b_w2_data", bus_b.data_o, -216);
    repeat (4) tick();
    checkOutput("b_b2b_done_valid", bus_b.valid_o, 0);

    // Reset while channel 1 of 4 is presented
    applyStimulusB(w_full, 1'b1, 1'b1);
    pushB(-4590, 0, 1'b0);
    pushB(2295, 1, 1'b0);
    pushB(-2295, 2, 1'b0);
    pushB(255, 3, 1'b1);
    tick();
    applyStimulusB('0, 1'b0, 1'b1);
    tick();
    checkOutput("b_midrst_pre_channel", bus_b.channel_o, 1);
    q_b.delete();
    rst_b_n = 1'b0;
    #1;
    checkOutput("b_midrst_valid", bus_b.valid_o, 0);
    checkOutput("b_midrst_channel", bus_b.channel_o, 0);
    tick();
    rst_b_n = 1'b1;
    #1;
    checkOutput("b_postrst_ready", bus_b.ready_o, 1);
    checkOutput("b_postrst_valid", bus_b.valid_o, 0);

    // Weights cleared: every channel of the next window yields zero
    applyStimulusB(w_full, 1'b1, 1'b1);
    pushB(0, 0, 1'b0);
    pushB(0, 1, 1'b0);
    pushB(0, 2, 1'b0);
    pushB(0, 3, 1'b1);
    tick();
    applyStimulusB('0, 1'b0, 1'b1);
    repeat (4) tick();

    // Drain both scoreboards within a bounded number of cycles
    for (int i = 0; i < 20 && (q_a.size() != 0 || q_b.size() != 0); i++) tick();
    checkOutput("queues_drained", q_a.size() + q_b.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
